// File: rtl/uart_mmio_pkg.sv
// Shared constants, types and helpers for the memory-mapped console UART.
//   UART_BASE      : default 8-byte-aligned register window base
//   UART_THR_OFF   : byte offset of THR (write) / RBR (read)
//   UART_LSR_OFF   : byte offset of the read-only line status register
//   LSR_*_BIT      : bit positions inside the LSR byte
//   lsr_byte()     : assembles the LSR byte from FIFO status
package uart_mmio_pkg;

  localparam logic [63:0] UART_BASE    = 64'h0000_0000_a000_03f8;
  localparam logic [2:0]  UART_THR_OFF = 3'd0;
  localparam logic [2:0]  UART_LSR_OFF = 3'd5;

  localparam int unsigned LSR_DR_BIT   = 0;  // receive data ready
  localparam int unsigned LSR_THRE_BIT = 5;  // transmit holding register has room
  localparam int unsigned LSR_TEMT_BIT = 6;  // transmitter fully drained

  typedef logic [7:0] uart_byte_t;

  // Data-ready is hard-wired: the harness reports "no character" as 0xff instead.
  function automatic uart_byte_t lsr_byte(input logic empty, input logic full);
    uart_byte_t b;
    b               = '0;
    b[LSR_DR_BIT]   = 1'b1;
    b[LSR_THRE_BIT] = ~full;
    b[LSR_TEMT_BIT] = empty;
    return b;
  endfunction

endpackage

// File: rtl/uart_mmio_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push/din : write din when not full
//   pop/dout : dout shows the head; pop advances it when not empty
//   full, empty, count : status derived from the registered count
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped console UART beside the mem stage.
//   clk, rst              : clock, asynchronous active-high reset
//   wen/waddr/wdata/wmask : mem-stage store (data and mask already lane-shifted)
//   ren/raddr/rdata       : mem-stage load; rdata is combinational
//   hit                   : current access targets the UART window
//   stall                 : THR store refused because the TX FIFO is full
//   uart_out_valid/_ch    : one-cycle character strobe towards the harness
//   uart_in_valid/_ch     : getc request and harness reply (0xff = none)
//   tx_cnt                : running count of emitted characters
module uart_mmio
  import uart_mmio_pkg::*;
#(
  parameter logic [63:0] BASE  = UART_BASE,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wen,
  input  logic [63:0] waddr,
  input  logic [63:0] wdata,
  input  logic [63:0] wmask,
  input  logic        ren,
  input  logic [63:0] raddr,
  output logic [63:0] rdata,
  output logic        hit,
  output logic        stall,
  output logic        uart_out_valid,
  output logic [7:0]  uart_out_ch,
  output logic        uart_in_valid,
  input  logic [7:0]  uart_in_ch,
  output logic [31:0] tx_cnt
);

  localparam int unsigned CW  = $clog2(DEPTH) + 1;
  localparam int unsigned PCW = (DIV > 1) ? $clog2(DIV) : 1;

  logic            whit;
  logic            rhit;
  logic [2:0]      woff;
  logic [2:0]      roff;
  logic            thr_wr;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  uart_byte_t      head;
  uart_byte_t      lsr;
  logic [PCW-1:0]  pc;

  // Only the THR lane byte and bit 7 of its mask are meaningful.
  logic unused_bits;
  assign unused_bits = ^{wdata[63:8], wmask[63:8], wmask[6:0]};

  // Address decode.
  assign whit = (waddr[63:3] == BASE[63:3]);
  assign rhit = (raddr[63:3] == BASE[63:3]);
  assign woff = waddr[2:0];
  assign roff = raddr[2:0];
  assign hit  = (wen & whit) | (ren & rhit);

  // A THR write is accepted or stalled on the registered full flag only.
  assign thr_wr = wen & whit & (woff == UART_THR_OFF) & wmask[7];
  assign push   = thr_wr & ~full;
  assign stall  = thr_wr & full;

  assign pop = (pc == '0) & ~empty;

  assign lsr           = lsr_byte(count == '0, count == CW'(DEPTH));
  assign uart_in_valid = ren & rhit & (roff == UART_THR_OFF);

  // Load data mux: RBR in byte 0, LSR in its own lane at offsets 0 and 5.
  always_comb begin
    rdata = '0;
    if (rhit) begin
      if (roff == UART_THR_OFF) rdata[7:0] = uart_in_ch;
      if (roff == UART_THR_OFF || roff == UART_LSR_OFF) rdata[47:40] = lsr;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Drain pacing: one character per DIV cycles, character held between strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc             <= '0;
      uart_out_valid <= 1'b0;
      uart_out_ch    <= '0;
      tx_cnt         <= '0;
    end else begin
      uart_out_valid <= pop;
      if (pop) begin
        uart_out_ch <= head;
        pc          <= PCW'(DIV - 1);
        tx_cnt      <= tx_cnt + 32'd1;
      end else if (pc != '0) begin
        pc <= pc - PCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench: three uart_mmio instances (DIV 1, 8, 16) share one
// randomized/directed stimulus stream; each is compared every cycle against
// a queue-based reference model of the register and drain rules.
module tb_uart_mmio;

  localparam logic [63:0] BASE = 64'h0000_0000_a000_03f8;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        wen, ren;
  logic [63:0] waddr, wdata, wmask, raddr;
  logic [7:0]  uart_in_ch;

  logic [63:0] rdata_o [NI];
  logic        hit_o   [NI];
  logic        stall_o [NI];
  logic        uov     [NI];
  logic [7:0]  uoc     [NI];
  logic        uiv     [NI];
  logic [31:0] txc     [NI];

  always #5 clk = ~clk;

  uart_mmio #(.DEPTH(8), .DIV(1)) u_dut_div1 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .raddr(raddr), .rdata(rdata_o[0]), .hit(hit_o[0]), .stall(stall_o[0]),
    .uart_out_valid(uov[0]), .uart_out_ch(uoc[0]), .uart_in_valid(uiv[0]),
    .uart_in_ch(uart_in_ch), .tx_cnt(txc[0]));

  uart_mmio #(.DEPTH(8), .DIV(8)) u_dut_div8 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .raddr(raddr), .rdata(rdata_o[1]), .hit(hit_o[1]), .stall(stall_o[1]),
    .uart_out_valid(uov[1]), .uart_out_ch(uoc[1]), .uart_in_valid(uiv[1]),
    .uart_in_ch(uart_in_ch), .tx_cnt(txc[1]));

  uart_mmio #(.DEPTH(8), .DIV(16)) u_dut_div16 (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .ren(ren), .raddr(raddr), .rdata(rdata_o[2]), .hit(hit_o[2]), .stall(stall_o[2]),
    .uart_out_valid(uov[2]), .uart_out_ch(uoc[2]), .uart_in_valid(uiv[2]),
    .uart_in_ch(uart_in_ch), .tx_cnt(txc[2]));

  // Reference model state.
  typedef logic [7:0] bq_t [$];
  bq_t         mq      [NI];
  int          m_pc    [NI];
  logic        m_valid [NI];
  logic [7:0]  m_ch    [NI];
  logic [31:0] m_tx    [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 8 : 16);
  endfunction

  function automatic logic in_win(logic [63:0] a);
    return (a >> 3) == (BASE >> 3);
  endfunction

  function automatic logic [7:0] m_lsr(int k);
    return {1'b0, mq[k].size() == 0, mq[k].size() != 8, 4'b0000, 1'b1};
  endfunction

  function automatic logic m_thr_wr();
    return wen && in_win(waddr) && (waddr % 8 == 0) && wmask[7];
  endfunction

  function automatic logic [63:0] m_rdata(int k);
    logic [63:0] r;
    int off;
    r   = 64'd0;
    off = int'(raddr % 8);
    if (in_win(raddr)) begin
      if (off == 0) r[7:0] = uart_in_ch;
      if (off == 0 || off == 5) r[47:40] = m_lsr(k);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      m_pc[k] = 0; m_valid[k] = 1'b0; m_ch[k] = 8'h00; m_tx[k] = 32'd0;
    end
  endtask

  // One clock edge of the reference: pop decision and full flag use pre-edge state.
  task automatic model_clock();
    for (int k = 0; k < NI; k++) begin
      logic was_full;
      was_full = (mq[k].size() == 8);
      if (m_pc[k] == 0 && mq[k].size() > 0) begin
        m_ch[k]    = mq[k].pop_front();
        m_valid[k] = 1'b1;
        m_tx[k]    = m_tx[k] + 32'd1;
        m_pc[k]    = div_of(k) - 1;
      end else begin
        m_valid[k] = 1'b0;
        if (m_pc[k] > 0) m_pc[k] = m_pc[k] - 1;
      end
      if (m_thr_wr() && !was_full) mq[k].push_back(wdata[7:0]);
    end
  endtask

  task automatic check_comb();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("hit%0d", k), hit_o[k], (wen && in_win(waddr)) || (ren && in_win(raddr)));
      check($sformatf("stall%0d", k), stall_o[k], m_thr_wr() && mq[k].size() == 8);
      check($sformatf("rdata%0d", k), rdata_o[k], m_rdata(k));
      check($sformatf("in_valid%0d", k), uiv[k], ren && in_win(raddr) && (raddr % 8 == 0));
    end
  endtask

  task automatic check_regs();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("out_valid%0d", k), uov[k], m_valid[k]);
      check($sformatf("out_ch%0d", k), uoc[k], m_ch[k]);
      check($sformatf("tx_cnt%0d", k), txc[k], m_tx[k]);
    end
  endtask

  // Inputs are set right after a negedge; returns the DIV=16 stall seen this cycle.
  task automatic cycle(output logic st16);
    #1;
    check_comb();
    st16 = stall_o[2];
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_regs();
  endtask

  task automatic idle(input int n);
    logic st;
    wen = 1'b0; ren = 1'b0;
    repeat (n) cycle(st);
  endtask

  task automatic store(input logic [63:0] a, input logic [7:0] d, input logic [63:0] m);
    wen = 1'b1; waddr = a; wdata = {$urandom, $urandom}; wdata[7:0] = d; wmask = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic st, saw_stall;
    int n;

    rst = 1'b1; wen = 1'b0; ren = 1'b0;
    waddr = '0; wdata = '0; wmask = '0; raddr = '0; uart_in_ch = 8'hff;
    model_reset();
    repeat (2) @(negedge clk);
    check_regs();
    rst = 1'b0;

    // Single character with DIV=1: strobe lands two cycles after acceptance.
    store(BASE, 8'h41, 64'hff);
    cycle(st);
    idle(20);

    // Receive register and LSR reads.
    uart_in_ch = 8'h5a; ren = 1'b1; raddr = BASE;
    #1 check("rbr_const", rdata_o[0], 64'h0000_6100_0000_005a);
    cycle(st);
    raddr = BASE + 64'd5;
    #1 check("lsr_const", rdata_o[0][47:40], 8'h61);
    check("lsr_no_getc", uiv[0], 1'b0);
    cycle(st);
    idle(2);

    // Stores that must not push.
    store(BASE + 64'd5, 8'h11, 64'hff); cycle(st);
    store(BASE, 8'h22, 64'h0);          cycle(st);
    store(BASE + 64'd8, 8'h33, 64'hff); cycle(st);
    idle(20);

    // Burst of ten stores; hold each while the DIV=16 instance stalls.
    saw_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      store(BASE, 8'h30 + 8'(i), 64'hff);
      n = 0;
      do begin
        cycle(st);
        n++;
        if (st) saw_stall = 1'b1;
      end while (st && n < 40);
      if (st) check("stall_release_timeout", 1'b1, 1'b0);
    end
    check("stall16_seen", saw_stall, 1'b1);
    idle(200);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [63:0] a;
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? BASE + 64'($urandom_range(0, 7)) :
          (sel == 2) ? BASE + 64'd8 + 64'($urandom_range(0, 7)) : {$urandom, $urandom};
      wen   = ($urandom_range(0, 1) == 1);
      waddr = a;
      wdata = {$urandom, $urandom};
      case ($urandom_range(0, 2))
        0:       wmask = 64'hff;
        1:       wmask = 64'h0;
        default: wmask = {$urandom, $urandom};
      endcase
      ren        = ($urandom_range(0, 1) == 1);
      sel        = $urandom_range(0, 3);
      raddr      = (sel < 3) ? BASE + 64'($urandom_range(0, 7)) : {$urandom, $urandom};
      uart_in_ch = 8'($urandom);
      cycle(st);
    end
    idle(200);

    // Continuous stores with simultaneous drains across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      store(BASE, 8'h80 + 8'(i), 64'hff);
      cycle(st);
      check("div1_no_stall", stall_o[0], 1'b0);
    end
    idle(200);

    // Asynchronous reset mid-drain on the DIV=8 instance.
    for (int i = 0; i < 3; i++) begin
      store(BASE, 8'h61 + 8'(i), 64'hff);
      cycle(st);
    end
    wen = 1'b0;
    n = 0;
    while (!uov[1] && n < 40) begin
      cycle(st);
      n++;
    end
    check("div8_strobe_before_rst", uov[1], 1'b1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_valid%0d", k), uov[k], 1'b0);
      check($sformatf("rst_tx%0d", k), txc[k], 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_regs();
    idle(40);
    ren = 1'b1; raddr = BASE + 64'd5;
    #1 check("lsr_after_rst", rdata_o[1][47:40], 8'h61);
    cycle(st);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
